// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). Optional active-low 7-segment
// outputs are compiled in when BCD_SEG_EN is defined.
module bcd_converter_seq #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
`ifdef BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic int unsigned pow10(input int n);
    int unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  localparam int unsigned   MAXV = pow10(DIGITS) - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_shreg;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf_flag;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_result;

  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
  end

  // Out-of-range inputs saturate to all nines instead of showing a wrapped value
  assign w_result = r_ovf_flag ? {DIGITS{4'h9}} : r_scratch;

`ifdef BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [7*DIGITS-1:0] w_seg;
  logic [7*DIGITS-1:0] w_seg_zero;

  always_comb begin
    w_seg      = '0;
    w_seg_zero = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_seg[7*d +: 7]      = seg7(w_result[4*d +: 4]);
      w_seg_zero[7*d +: 7] = seg7(4'd0);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_flag <= 1'b0;
      bcd        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
`ifdef BCD_SEG_EN
      seg        <= w_seg_zero;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_shreg    <= bin;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_flag <= (32'(bin) > MAXV);
            busy       <= 1'b1;
            r_state    <= S_ADJ;
          end
        end
        S_ADJ: begin
          r_scratch <= w_adj;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_scratch, r_shreg} <= {r_scratch, r_shreg} << 1;
          if (r_cnt == LAST) begin
            r_state <= S_FIN;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_state <= S_ADJ;
          end
        end
        S_FIN: begin
          bcd     <= w_result;
          ovf     <= r_ovf_flag;
`ifdef BCD_SEG_EN
          seg     <= w_seg;
`endif
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: default instance plus a one-digit
// instance for the saturation path; seg checks only when BCD_SEG_EN is defined.
module tb_bcd_converter_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic [5:0] bin = '0;
  logic [7:0] bcd;
  logic       busy, done, ovf;

  logic       init1 = 1'b0;
  logic [5:0] bin1 = '0;
  logic [3:0] bcd1;
  logic       busy1, done1, ovf1;

`ifdef BCD_SEG_EN
  logic [13:0] seg;
  logic [6:0]  seg1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_converter_seq #(.WIDTH(6), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .init(init), .bin(bin),
    .bcd(bcd), .busy(busy), .done(done), .ovf(ovf)
`ifdef BCD_SEG_EN
    , .seg(seg)
`endif
  );

  bcd_converter_seq #(.WIDTH(6), .DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .init(init1), .bin(bin1),
    .bcd(bcd1), .busy(busy1), .done(done1), .ovf(ovf1)
`ifdef BCD_SEG_EN
    , .seg(seg1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [5:0] b, input logic [7:0] eb, input string tag);
    int   k;
    logic gap;
    @(negedge clk);
    init = 1'b1;
    bin  = b;
    @(negedge clk);
    init = 1'b0;
    bin  = ~b;
    chk({tag, "_busy_start"}, busy, 1);
    k   = 0;
    gap = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (!done && !busy) gap = 1'b1;
    end
    chk({tag, "_latency"}, k, 13);
    chk({tag, "_bcd"}, bcd, eb);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_busy_gap"}, gap, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int k, nd;
    int t[4];

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_bcd", bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
`ifdef BCD_SEG_EN
    chk("rst_seg", seg, 14'b1000000_1000000);
`endif

    convert(6'd42, 8'h42, "c42");
`ifdef BCD_SEG_EN
    chk("seg42", seg, 14'b0011001_0100100);
`endif
    convert(6'd0, 8'h00, "c0");
    convert(6'd63, 8'h63, "c63");
    convert(6'd19, 8'h19, "c19");

    // init while busy is ignored
    @(negedge clk);
    init = 1'b1;
    bin  = 6'd42;
    @(negedge clk);
    init = 1'b0;
    nd = 0;
    for (k = 1; k <= 30; k++) begin
      if (k == 4) begin init = 1'b1; bin = 6'd7; end
      if (k == 5) init = 1'b0;
      @(negedge clk);
      if (done) begin
        nd++;
        chk("busy_init_bcd", bcd, 8'h42);
      end
    end
    chk("busy_init_dones", nd, 1);

    // init held high: back-to-back conversions every 14 cycles
    @(negedge clk);
    init = 1'b1;
    bin  = 6'd21;
    nd = 0;
    t = '{0, 0, 0, 0};
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        if (nd < 4) t[nd] = k;
        nd++;
        chk("hold_bcd", bcd, 8'h21);
      end
    end
    init = 1'b0;
    chk("hold_first", t[0], 14);
    chk("hold_period1", t[1] - t[0], 14);
    chk("hold_period2", t[2] - t[1], 14);
    repeat (20) @(negedge clk);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk);
    init = 1'b1;
    bin  = 6'd55;
    @(negedge clk);
    init = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd, 0);
    nd = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    convert(6'd9, 8'h09, "c9");

    // single-digit instance: saturation and recovery
    @(negedge clk);
    init1 = 1'b1;
    bin1  = 6'd42;
    @(negedge clk);
    init1 = 1'b0;
    k = 0;
    while (!done1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("d1_lat", k, 13);
    chk("d1_sat_bcd", bcd1, 4'h9);
    chk("d1_sat_ovf", ovf1, 1);
`ifdef BCD_SEG_EN
    chk("d1_sat_seg", seg1, 7'b0010000);
`endif
    @(negedge clk);
    init1 = 1'b1;
    bin1  = 6'd7;
    @(negedge clk);
    init1 = 1'b0;
    k = 0;
    while (!done1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("d1_7_bcd", bcd1, 4'h7);
    chk("d1_7_ovf", ovf1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
